// File: rtl/mdu_pipe_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, op-class helpers.
package mdu_pipe_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MADD  = 4'd4;
    localparam logic [3:0] MD_MADDU = 4'd5;
    localparam logic [3:0] MD_MSUB  = 4'd6;
    localparam logic [3:0] MD_MSUBU = 4'd7;
    localparam logic [3:0] MD_MTHI  = 4'd8;
    localparam logic [3:0] MD_MTLO  = 4'd9;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Arithmetic ops occupy the low encodings and are the only ones that enter RUN.
    function automatic logic md_is_arith(input logic [3:0] op);
        return op <= MD_MSUBU;
    endfunction

endpackage

// File: rtl/mdu_pipe_md_calc.sv
// Combinational datapath: given captured operands, op and current HI/LO, produce next HI/LO.
module mdu_pipe_md_calc
    import mdu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic             sgn;
    logic [W2-1:0]    acc, a_ext, b_ext, prod;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    always_comb begin
        sgn   = op_i inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
        acc   = {hi_i, lo_i};
        a_ext = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        b_ext = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        // Low 2*WIDTH bits of the extended product are exact for both signednesses.
        prod  = a_ext * b_ext;

        // Divide on magnitudes; min_int / -1 naturally yields min_int with remainder 0.
        a_mag = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quo   = (sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1])) ? -q_mag : q_mag;
        rem   = (sgn && a_i[WIDTH-1]) ? -r_mag : r_mag;

        {hi_o, lo_o} = acc;
        case (op_i)
            MD_MULT, MD_MULTU: {hi_o, lo_o} = prod;
            MD_MADD, MD_MADDU: {hi_o, lo_o} = acc + prod;
            MD_MSUB, MD_MSUBU: {hi_o, lo_o} = acc - prod;
            MD_DIV, MD_DIVU: begin
                if (b_i != '0) begin
                    hi_o = rem;
                    lo_o = quo;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_pipe.sv
// E-stage multiply/divide unit: owns HI/LO, counts down per-class latency, exposes busy for stalls.
module mdu_pipe
    import mdu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             hl_sel,
    output logic             busy,
    output logic [WIDTH-1:0] rd
);

    if (MULT_LAT < 1 || DIV_LAT < 1 ||
        MULT_LAT > (2 ** CNT_W) - 1 || DIV_LAT > (2 ** CNT_W) - 1) begin : g_lat_check
        $error("mdu_pipe: MULT_LAT/DIV_LAT must be in 1..2^CNT_W-1");
    end

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] calc_hi, calc_lo;

    // HI/LO cannot change during RUN, so the live registers equal the capture-time values.
    mdu_pipe_md_calc #(
        .WIDTH(WIDTH)
    ) u_md_calc (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    if (md_op == MD_MTHI) begin
                        hi_d = A;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = A;
                    end else if (md_is_arith(md_op)) begin
                        op_d    = md_op;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = md_is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    hi_d    = calc_hi;
                    lo_d    = calc_lo;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == StRun);
    assign rd   = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Self-checking bench for mdu_pipe: directed literal cases, then random traffic vs a behavioural model.
module tb_mdu_pipe;
    import mdu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush, hl_sel, busy;
    logic [3:0]  md_op;
    logic [31:0] A, B, rd;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mdu_pipe #(
        .WIDTH   (32),
        .MULT_LAT(5),
        .DIV_LAT (10),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .hl_sel(hl_sel),
        .busy  (busy),
        .rd    (rd)
    );

    // Behavioural model: architectural HI/LO, cycles left busy, and the result due at the end.
    logic [31:0] m_hi, m_lo;
    int          m_busy;
    logic [63:0] m_pend;
    logic        m_wr;

    function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb, sq, sr;
        logic [63:0] sp, up, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (op)
            MD_MULT:  return sp;
            MD_MULTU: return up;
            MD_MADD:  return acc + sp;
            MD_MADDU: return acc + up;
            MD_MSUB:  return acc - sp;
            MD_MSUBU: return acc - up;
            MD_DIV: begin
                if (b == 32'd0) return acc;
                sq = sa / sb;
                sr = sa % sb;
                qv = sq;
                rv = sr;
                return {rv[31:0], qv[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_busy <= 0;
            m_pend <= 64'd0;
            m_wr   <= 1'b0;
        end else if (m_busy != 0) begin
            if (flush) begin
                m_busy <= 0;
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1 && m_wr) {m_hi, m_lo} <= m_pend;
            end
        end else if (start && !flush) begin
            if (md_op == MD_MTHI) m_hi <= A;
            else if (md_op == MD_MTLO) m_lo <= A;
            else if (md_op <= MD_MSUBU) begin
                m_pend <= md_model(md_op, A, B, {m_hi, m_lo});
                m_wr   <= !((md_op == MD_DIV || md_op == MD_DIVU) && B == 32'd0);
                m_busy <= (md_op == MD_DIV || md_op == MD_DIVU) ? 10 : 5;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== (m_busy != 0)) begin
                failures++;
                $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, busy, m_busy != 0);
            end
            checks++;
            if (rd !== (hl_sel ? m_hi : m_lo)) begin
                failures++;
                $display("FAIL cyc_rd t=%0t sel=%b got=%h want=%h", $time, hl_sel, rd,
                         hl_sel ? m_hi : m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Checks DUT read port and the model against literal HI/LO.
    task automatic chk_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
        hl_sel = 1'b1;
        #1;
        chk({name, "_hi"}, rd, hi);
        hl_sel = 1'b0;
        #1;
        chk({name, "_lo"}, rd, lo);
        chk({name, "_model_hi"}, m_hi, hi);
        chk({name, "_model_lo"}, m_lo, lo);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        hl_sel = 1'b0;
        md_op  = 4'd0;
        A      = 32'd0;
        B      = 32'd0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk_hl("reset", 32'd0, 32'd0);

        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("mult_lat", 32'(n), 32'd5);
        chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("multu_lat", 32'(n), 32'd5);
        chk_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_lat", 32'(n), 32'd10);
        chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk_hl("div_ovf", 32'd0, 32'h8000_0000);

        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        chk("mthi_busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk);
        chk("mtlo_busy", 32'(busy), 32'd0);
        issue(MD_MADDU, 32'h10, 32'h10);
        wait_idle(n);
        chk("maddu_lat", 32'(n), 32'd5);
        chk_hl("maddu", 32'h1234_5679, 32'h0000_00FF);

        issue(MD_MTHI, 32'hAA, 32'd0);
        issue(MD_MTLO, 32'hBB, 32'd0);
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_idle(n);
        chk("divz_lat", 32'(n), 32'd10);
        chk_hl("divz", 32'hAA, 32'hBB);

        // Flush on the second busy cycle aborts without writing.
        issue(MD_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #2;
        chk_hl("flush", 32'hAA, 32'hBB);

        // Flush together with start in IDLE captures nothing.
        @(posedge clk);
        #2;
        start = 1'b1;
        flush = 1'b1;
        md_op = MD_MTHI;
        A     = 32'h5555;
        @(posedge clk);
        #2;
        start = 1'b0;
        flush = 1'b0;
        chk_hl("flush_start", 32'hAA, 32'hBB);

        // Start during RUN is ignored.
        issue(MD_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #2;
        start = 1'b1;
        md_op = MD_MTHI;
        A     = 32'hDEAD;
        @(posedge clk);
        #2 start = 1'b0;
        wait_idle(n);
        chk_hl("run_start", 32'd0, 32'd12);

        // Asynchronous reset on the third cycle of a divide.
        issue(MD_DIV, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk_hl("rst_mid", 32'd0, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk_hl("rst_after", 32'd0, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            start  = ($urandom_range(0, 3) == 0);
            md_op  = 4'($urandom_range(0, 9));
            A      = pick();
            B      = pick();
            flush  = ($urandom_range(0, 19) == 0);
            hl_sel = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        flush = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO register pair and models instruction latency with a countdown.
- Exposes a busy flag that the stall unit combines with start, so that MD-class instructions in D are held while the unit is busy.
- Extends the previous single-cycle arithmetic with configurable width, per-class latency, multiply-accumulate ops and a flush input.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, cycles busy for mult/multu/madd/maddu/msub/msubu (>=1).
- DIV_LAT, 10, cycles busy for div/divu (>=1).
- CNT_W, 4, countdown width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is an MD op (mult..divu, madd..msubu, mthi, mtlo); sampled at the clock edge.
- md_op  in  4  operation code from the shared constants.
- A  in  WIDTH  forwarded rs value.
- B  in  WIDTH  forwarded rt value.
- flush  in  1  abort any in-flight operation; HI/LO left unchanged.
- hl_sel  in  1  read select: 0 = LO, 1 = HI (mflo/mfhi).
- busy  out  1  registered; high while an operation counts down.
- rd  out  WIDTH  combinational read of HI or LO per hl_sel.

Behaviour:
- Reset (reset low, asynchronous) clears HI, LO, counter and captured operands; state goes to IDLE; busy = 0.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1, counter counts down.
- IDLE, start=1, arithmetic op at edge k:
  - Capture A, B and op.
  - Load counter with MULT_LAT or DIV_LAT by op class.
  - Go to RUN.
- IDLE, start=1, mthi/mtlo at edge k: write HI or LO with A at edge k; stay IDLE; busy stays 0.
- RUN: counter decrements each edge. When it reaches 1 at an edge:
  - Write the result to HI/LO.
  - Go to IDLE.
  - Net effect: busy is high for exactly LAT cycles and the result is visible on rd in the cycle busy falls.
- start while in RUN: ignored; the stall unit guarantees this never happens. The bench checks that HI/LO are unaffected.
- flush=1:
  - In RUN: return to IDLE next edge; no HI/LO write.
  - With a simultaneous start in IDLE: flush wins, nothing is captured.
- Arithmetic (full 2*WIDTH product):
  - mult / multu: {HI,LO} = A*B, signed / unsigned.
  - madd / maddu: {HI,LO} += A*B.
  - msub / msubu: {HI,LO} -= A*B.
  - Accumulate ops use the HI/LO value held at capture time; wrap modulo 2^(2*WIDTH).
  - div / divu: LO = quotient, HI = remainder. The signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero: HI/LO unchanged; the full latency is still consumed.
  - Signed overflow (min_int / -1): LO = min_int, HI = 0.
- Read path: rd is not bypassed with a pending result. mfhi/mflo issued while busy are stalled externally, so rd always reflects committed HI/LO.
- Latency counter never wraps: a parameter check fails elaboration if a LAT value is < 1 or exceeds 2^CNT_W-1.

Decomposition:
- md_op encodings go in the shared constant header as `MD_* defines, next to the existing ALU/NPC op codes:
  - MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- The stall unit's MD-stall condition (D is an MD op and (start|busy)) lives in the stall unit, not here.
- One natural sub-module, md_calc: purely combinational, WIDTH-parametrised. It takes captured operands, op and old HI/LO and returns next {HI,LO}. mdu_pipe keeps the FSM, counter and registers.

Test Plan:
- Reset low mid-RUN (cycle 3 of a div) -> busy=0 immediately; HI=LO=0; no later write.
- mult A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678, then maddu A=0x10, B=0x10 with LO=0xFFFFFFFF -> HI=0x12345679, LO=0x000000FF. Confirm mthi leaves busy=0 throughout.
- divu B=0 with HI=0xAA, LO=0xBB -> busy high 10 cycles; HI/LO stay 0xAA/0xBB.
- Start mult, assert flush on busy cycle 2 -> busy=0 next cycle; HI/LO unchanged. A start pulse during RUN (forced) is ignored.
